logic_axi4_stream_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares one downstream AXI4-Stream datapath (typically a width upsizer) between INPUTS requesters.
- Sits directly in front of the shared resource; grants one input per packet and holds the grant until that input's tlast beat is transferred.
- Single registered output stage gives 1-cycle data latency; no combinational path from tx_tready to tx_tvalid.

---
 rtl/logic_axi4_stream_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_logic_axi4_stream_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_axi4_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI4-Stream output between INPUTS requesters.
// Optional macro LOGIC_AXI4_STREAM_ARBITER_TID_OVERRIDE_EN: tx_tid carries the granted input index.
module logic_axi4_stream_arbiter #(
  parameter int INPUTS      = 4,
  parameter int TDATA_BYTES = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter int USE_TLAST   = 1,
  parameter int USE_TKEEP   = 1
) (
  input  logic                              aclk,
  input  logic                              areset_n,
  input  logic [INPUTS-1:0]                 rx_tvalid,
  output logic [INPUTS-1:0]                 rx_tready,
  input  logic [INPUTS-1:0]                 rx_tlast,
  input  logic [INPUTS*TDATA_BYTES*8-1:0]   rx_tdata,
  input  logic [INPUTS*TDATA_BYTES-1:0]     rx_tkeep,
  input  logic [INPUTS*TUSER_WIDTH-1:0]     rx_tuser,
  input  logic [INPUTS*TDEST_WIDTH-1:0]     rx_tdest,
  input  logic [INPUTS*TID_WIDTH-1:0]       rx_tid,
  output logic                              tx_tvalid,
  input  logic                              tx_tready,
  output logic                              tx_tlast,
  output logic [TDATA_BYTES*8-1:0]          tx_tdata,
  output logic [TDATA_BYTES-1:0]            tx_tkeep,
  output logic [TUSER_WIDTH-1:0]            tx_tuser,
  output logic [TDEST_WIDTH-1:0]            tx_tdest,
  output logic [TID_WIDTH-1:0]              tx_tid
);

  localparam int DW    = TDATA_BYTES * 8;
  localparam int KW    = TDATA_BYTES;
  localparam int IDX_W = $clog2(INPUTS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                  state_r;
  logic [IDX_W-1:0]        grant_r;
  logic [IDX_W-1:0]        last_grant_r;
  logic [IDX_W-1:0]        pick_s;

  logic                    tx_tvalid_r;
  logic                    tx_tlast_r;
  logic [DW-1:0]           tx_tdata_r;
  logic [KW-1:0]           tx_tkeep_r;
  logic [TUSER_WIDTH-1:0]  tx_tuser_r;
  logic [TDEST_WIDTH-1:0]  tx_tdest_r;
  logic [TID_WIDTH-1:0]    tx_tid_r;

  logic [INPUTS-1:0]       rx_tready_s;
  logic                    rx_hs_s;
  logic                    tx_hs_s;
  logic                    eop_s;

  logic [DW-1:0]           data_a_s [INPUTS];
  logic [KW-1:0]           keep_a_s [INPUTS];
  logic [TUSER_WIDTH-1:0]  user_a_s [INPUTS];
  logic [TDEST_WIDTH-1:0]  dest_a_s [INPUTS];
  logic [TID_WIDTH-1:0]    tid_a_s  [INPUTS];

  logic                    sel_last_s;
  logic [DW-1:0]           sel_data_s;
  logic [KW-1:0]           sel_keep_s;
  logic [TUSER_WIDTH-1:0]  sel_user_s;
  logic [TDEST_WIDTH-1:0]  sel_dest_s;
  logic [TID_WIDTH-1:0]    sel_tid_s;

`ifdef LOGIC_AXI4_STREAM_ARBITER_TID_OVERRIDE_EN
  if (TID_WIDTH < $clog2(INPUTS)) begin : g_tid_width_check
    $error("TID_WIDTH too narrow to carry the granted input index");
  end
`endif

  // First requester after the previous winner, wrapping modulo INPUTS.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [INPUTS-1:0] req,
                                              input logic [IDX_W-1:0]  last);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= INPUTS; k++) begin
      cand = IDX_W'((int'(last) + k) % INPUTS);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Unpack the per-input slices into indexable arrays.
  always_comb begin
    for (int i = 0; i < INPUTS; i++) begin
      data_a_s[i] = rx_tdata[i*DW +: DW];
      keep_a_s[i] = rx_tkeep[i*KW +: KW];
      user_a_s[i] = rx_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
      dest_a_s[i] = rx_tdest[i*TDEST_WIDTH +: TDEST_WIDTH];
      tid_a_s[i]  = rx_tid[i*TID_WIDTH +: TID_WIDTH];
    end
  end

  // Ready only for the granted input, and only when the output register can take a beat.
  always_comb begin
    rx_tready_s = '0;
    if (state_r == ST_BUSY) begin
      rx_tready_s[grant_r] = !tx_tvalid_r || tx_tready;
    end else begin
      rx_tready_s = '0;
    end
    rx_hs_s = rx_tvalid[grant_r] && rx_tready_s[grant_r];
    tx_hs_s = tx_tvalid_r && tx_tready;
    eop_s   = rx_hs_s && ((USE_TLAST == 0) || rx_tlast[grant_r]);
    pick_s  = rr_pick(rx_tvalid, last_grant_r);
  end

  // Payload of the granted slice, with the constant-field options applied.
  always_comb begin
    sel_last_s = (USE_TLAST != 0) ? rx_tlast[grant_r] : 1'b1;
    sel_data_s = data_a_s[grant_r];
    sel_keep_s = (USE_TKEEP != 0) ? keep_a_s[grant_r] : {KW{1'b1}};
    sel_user_s = user_a_s[grant_r];
    sel_dest_s = dest_a_s[grant_r];
`ifdef LOGIC_AXI4_STREAM_ARBITER_TID_OVERRIDE_EN
    sel_tid_s  = TID_WIDTH'(grant_r);
`else
    sel_tid_s  = tid_a_s[grant_r];
`endif
  end

  // Arbitration FSM plus the single output register stage.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_r      <= ST_IDLE;
      grant_r      <= '0;
      last_grant_r <= IDX_W'(INPUTS - 1);
      tx_tvalid_r  <= 1'b0;
      tx_tlast_r   <= 1'b0;
      tx_tdata_r   <= '0;
      tx_tkeep_r   <= '0;
      tx_tuser_r   <= '0;
      tx_tdest_r   <= '0;
      tx_tid_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|rx_tvalid) begin
            grant_r <= pick_s;
            state_r <= ST_BUSY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (eop_s) begin
            last_grant_r <= grant_r;
            state_r      <= ST_IDLE;
          end else begin
            state_r <= ST_BUSY;
          end
        end
        default: state_r <= ST_IDLE;
      endcase

      // A new beat wins over draining, so back-to-back beats flow at full rate.
      if (rx_hs_s) begin
        tx_tvalid_r <= 1'b1;
        tx_tlast_r  <= sel_last_s;
        tx_tdata_r  <= sel_data_s;
        tx_tkeep_r  <= sel_keep_s;
        tx_tuser_r  <= sel_user_s;
        tx_tdest_r  <= sel_dest_s;
        tx_tid_r    <= sel_tid_s;
      end else if (tx_hs_s) begin
        tx_tvalid_r <= 1'b0;
      end else begin
        tx_tvalid_r <= tx_tvalid_r;
      end
    end
  end

  assign rx_tready = rx_tready_s;
  assign tx_tvalid = tx_tvalid_r;
  assign tx_tlast  = tx_tlast_r;
  assign tx_tdata  = tx_tdata_r;
  assign tx_tkeep  = tx_tkeep_r;
  assign tx_tuser  = tx_tuser_r;
  assign tx_tdest  = tx_tdest_r;
  assign tx_tid    = tx_tid_r;

endmodule

// File: tb/tb_logic_axi4_stream_arbiter.sv
// Scoreboard bench for logic_axi4_stream_arbiter: per-input source queues, expected tx beats
// queued in hand-computed grant order, and a monitor that checks every tx handshake.
module tb_logic_axi4_stream_arbiter;

  localparam int N     = 4;
  localparam int IW    = 2;
  localparam int DEPTH = 16;

  logic            aclk;
  logic            areset_n;
  logic [N-1:0]    rx_tvalid, rx_tready, rx_tlast;
  logic [N*8-1:0]  rx_tdata;
  logic [N-1:0]    rx_tkeep, rx_tuser, rx_tdest;
  logic [N*IW-1:0] rx_tid;
  logic            tx_tvalid, tx_tready, tx_tlast;
  logic [7:0]      tx_tdata;
  logic [0:0]      tx_tkeep, tx_tuser, tx_tdest;
  logic [IW-1:0]   tx_tid;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [10:0] src_mem [N][DEPTH];
  int          src_wr [N];
  int          src_rd [N];
  logic [13:0] exp_q [$];
  int          tx_cyc_q [$];

  logic [7:0] t2_d [10] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h40, 8'h41};
  int         t2_s [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

  logic_axi4_stream_arbiter #(
    .INPUTS(N), .TDATA_BYTES(1), .TUSER_WIDTH(1), .TDEST_WIDTH(1),
    .TID_WIDTH(IW), .USE_TLAST(1), .USE_TKEEP(1)
  ) dut (
    .aclk(aclk), .areset_n(areset_n),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tlast(rx_tlast),
    .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tuser(rx_tuser),
    .rx_tdest(rx_tdest), .rx_tid(rx_tid),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tlast(tx_tlast),
    .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep), .tx_tuser(tx_tuser),
    .tx_tdest(tx_tdest), .tx_tid(tx_tid)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    forever begin
      @(posedge aclk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [1:0] tid_of(input logic [7:0] d);
    return ~d[5:4] ^ {1'b0, d[0]};
  endfunction

  // Expected beat: {tid, dest, user, keep, last, data}; user/dest/keep come from data bits.
  function automatic logic [13:0] pack_exp(input int src, input logic [7:0] d, input logic l,
                                           input logic [1:0] t);
    logic [1:0] et;
`ifdef LOGIC_AXI4_STREAM_ARBITER_TID_OVERRIDE_EN
    et = 2'(src);
`else
    et = t;
`endif
    return {et, d[1], d[0], d[2], l, d};
  endfunction

  task automatic src_push(input int src, input logic [7:0] d, input logic l, input logic [1:0] t);
    src_mem[src][src_wr[src] % DEPTH] = {t, l, d};
    src_wr[src]++;
  endtask

  task automatic exp_push(input int src, input logic [7:0] d, input logic l, input logic [1:0] t);
    exp_q.push_back(pack_exp(src, d, l, t));
  endtask

  task automatic tick;
    @(posedge aclk);
    #2;
  endtask

  function automatic bit sources_empty;
    bit e;
    e = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (src_rd[i] != src_wr[i]) e = 1'b0;
    end
    return e;
  endfunction

  task automatic wait_drain(input string name, input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !sources_empty()) && n < max) begin
      tick;
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Source driver: presents each input's queue head, advancing on the handshake seen before the edge.
  initial begin
    logic [N-1:0] hs_rec;
    logic [10:0]  e;
    rx_tvalid = '0; rx_tlast = '0; rx_tdata = '0;
    rx_tkeep  = '0; rx_tuser = '0; rx_tdest = '0; rx_tid = '0;
    forever begin
      @(negedge aclk);
      hs_rec = rx_tvalid & rx_tready & {N{areset_n}};
      @(posedge aclk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs_rec[i] === 1'b1) src_rd[i]++;
        if (src_rd[i] < src_wr[i]) begin
          e = src_mem[i][src_rd[i] % DEPTH];
          rx_tvalid[i]        = 1'b1;
          rx_tlast[i]         = e[8];
          rx_tdata[i*8 +: 8]  = e[7:0];
          rx_tkeep[i]         = e[2];
          rx_tuser[i]         = e[0];
          rx_tdest[i]         = e[1];
          rx_tid[i*IW +: IW]  = e[10:9];
        end else begin
          rx_tvalid[i] = 1'b0;
          rx_tlast[i]  = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard pops on tx handshakes; stalled beats must stay stable with rx_tready low.
  initial begin
    logic [13:0] act, held, expv;
    bit          held_valid;
    held_valid = 1'b0;
    forever begin
      @(negedge aclk);
      act = {tx_tid, tx_tdest, tx_tuser, tx_tkeep, tx_tlast, tx_tdata};
      if (areset_n !== 1'b1) begin
        held_valid = 1'b0;
      end else if (tx_tvalid === 1'b1) begin
        if (held_valid) check("stall_payload_stable", act, held);
        if (tx_tready === 1'b1) begin
          tx_cyc_q.push_back(cyc);
          held_valid = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", act, 14'h0000);
            if (act == 14'h0000) begin
              errors++;
              $display("FAIL unexpected_beat: got beat 0x%0h with nothing expected", act);
            end
          end else begin
            expv = exp_q.pop_front();
            check("tx_beat", act, expv);
          end
        end else begin
          check("stall_rx_tready", rx_tready, 4'b0000);
          held       = act;
          held_valid = 1'b1;
        end
      end else begin
        held_valid = 1'b0;
      end
    end
  end

  initial begin
    int base;
    int c0;
    int n;
    areset_n  = 1'b0;
    tx_tready = 1'b1;
    tick;
    tick;
    check("reset_tx_tvalid", tx_tvalid, 1'b0);
    check("reset_rx_tready", rx_tready, 4'b0000);
    check("reset_tx_tdata", tx_tdata, 8'h00);
    areset_n = 1'b1;
    tick;

    // Single 3-beat packet from input 2.
    base = tx_cyc_q.size();
    c0   = cyc;
    src_push(2, 8'hA1, 1'b0, 2'd1); exp_push(2, 8'hA1, 1'b0, 2'd1);
    src_push(2, 8'hA2, 1'b0, 2'd2); exp_push(2, 8'hA2, 1'b0, 2'd2);
    src_push(2, 8'hA3, 1'b1, 2'd3); exp_push(2, 8'hA3, 1'b1, 2'd3);
    wait_drain("t1_drain", 40);
    check("t1_beat_count", tx_cyc_q.size() - base, 3);
    if (tx_cyc_q.size() >= base + 3) begin
      check("t1_first_latency", tx_cyc_q[base], c0 + 3);
      check("t1_consecutive_1", tx_cyc_q[base+1] - tx_cyc_q[base], 1);
      check("t1_consecutive_2", tx_cyc_q[base+2] - tx_cyc_q[base+1], 1);
    end
    check("t1_ready_after_last", rx_tready, 4'b0000);
    check("t1_tvalid_after_drain", tx_tvalid, 1'b0);

    // Fresh reset, then all inputs busy: grant order 0,1,2,3,0.
    areset_n = 1'b0;
    tick;
    areset_n = 1'b1;
    tick;
    for (int k = 0; k < 10; k++) src_push(t2_s[k], t2_d[k], t2_d[k][0], tid_of(t2_d[k]));
    for (int k = 0; k < 10; k++) exp_push(t2_s[k], t2_d[k], t2_d[k][0], tid_of(t2_d[k]));
    wait_drain("t2_drain", 80);

    // Input 1 packet with tx_tready pattern 1,0,0,1.
    src_push(1, 8'h51, 1'b0, tid_of(8'h51)); exp_push(1, 8'h51, 1'b0, tid_of(8'h51));
    src_push(1, 8'h52, 1'b0, tid_of(8'h52)); exp_push(1, 8'h52, 1'b0, tid_of(8'h52));
    src_push(1, 8'h53, 1'b0, tid_of(8'h53)); exp_push(1, 8'h53, 1'b0, tid_of(8'h53));
    src_push(1, 8'h54, 1'b1, tid_of(8'h54)); exp_push(1, 8'h54, 1'b1, tid_of(8'h54));
    for (int k = 0; k < 12; k++) begin
      tx_tready = (k % 4 == 1 || k % 4 == 2) ? 1'b0 : 1'b1;
      tick;
    end
    tx_tready = 1'b1;
    wait_drain("t3_drain", 40);

    // Input 3 requests while input 0's packet is in flight.
    base = tx_cyc_q.size();
    src_push(0, 8'h61, 1'b0, tid_of(8'h61)); exp_push(0, 8'h61, 1'b0, tid_of(8'h61));
    src_push(0, 8'h62, 1'b0, tid_of(8'h62)); exp_push(0, 8'h62, 1'b0, tid_of(8'h62));
    src_push(0, 8'h63, 1'b1, tid_of(8'h63)); exp_push(0, 8'h63, 1'b1, tid_of(8'h63));
    n = 0;
    while (rx_tready[0] !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check("t4_grant0", rx_tready[0], 1'b1);
    src_push(3, 8'h71, 1'b0, tid_of(8'h71)); exp_push(3, 8'h71, 1'b0, tid_of(8'h71));
    src_push(3, 8'h72, 1'b1, tid_of(8'h72)); exp_push(3, 8'h72, 1'b1, tid_of(8'h72));
    wait_drain("t4_drain", 40);
    if (tx_cyc_q.size() >= base + 4) begin
      check("t4_idle_bubble", tx_cyc_q[base+3] - tx_cyc_q[base+2], 2);
    end else begin
      check("t4_beat_count", tx_cyc_q.size() - base, 5);
    end

    // Reset mid-packet with a beat stuck in the output register.
    tx_tready = 1'b0;
    src_push(2, 8'h81, 1'b0, tid_of(8'h81));
    src_push(2, 8'h82, 1'b1, tid_of(8'h82));
    n = 0;
    while (tx_tvalid !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check("t5_stalled_data", tx_tdata, 8'h81);
    src_push(0, 8'h90, 1'b0, tid_of(8'h90)); exp_push(0, 8'h90, 1'b0, tid_of(8'h90));
    src_push(0, 8'h91, 1'b1, tid_of(8'h91)); exp_push(0, 8'h91, 1'b1, tid_of(8'h91));
    exp_push(2, 8'h82, 1'b1, tid_of(8'h82));
    areset_n = 1'b0;
    tick;
    check("t5_reset_tx_tvalid", tx_tvalid, 1'b0);
    check("t5_reset_rx_tready", rx_tready, 4'b0000);
    areset_n  = 1'b1;
    tx_tready = 1'b1;
    wait_drain("t5_drain", 40);

    // Input 3 packet with rx_tid=0: index appears on tx_tid only with the override build.
    src_push(3, 8'hB0, 1'b0, 2'd0); exp_push(3, 8'hB0, 1'b0, 2'd0);
    src_push(3, 8'hB1, 1'b1, 2'd0); exp_push(3, 8'hB1, 1'b1, 2'd0);
    wait_drain("t6_drain", 40);
    tick;
    check("end_tx_tvalid", tx_tvalid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
